fb_scan_arbiter: RTL and testbench
==================================

FB_SCAN_ARBITER -- requirements
Module: fb_scan_arbiter

Interface
REQ-001 SHALL have parameter FB_WORDS, 38400, number of framebuffer words (640x480 at 8 pixels/word).
REQ-002 SHALL have parameter FIFO_DEPTH, 4, display prefetch FIFO depth in words.
REQ-003 SHALL have ports, clock and reset first:
- Clk  in  1  sole clock, rising edge.
- Reset  in  1  asynchronous, active-high.
- CounterX  in  16  raster column.
- CounterY  in  16  raster row.
- hblank  in  1  horizontal blank, registered.
- vblank  in  1  vertical blank, registered.
- mem_addr  out  16  framebuffer RAM address.
- mem_we  out  1  RAM write strobe.
- mem_wdata  out  8  RAM write data.
- mem_rdata  in  8  RAM read data, valid exactly 1 cycle after the address.
- cpu_req  in  1  CPU write request, held until acked.
- cpu_addr  in  16  CPU write address, stable while cpu_req=1.
- cpu_wdata  in  8  CPU write data, stable while cpu_req=1.
- cpu_ack  out  1  one-cycle write-done pulse.
- pix_word  out  8  current 8-pixel display word, MSB = leftmost pixel.
- underflow_cnt  out  8  saturating display-underflow count.

Function
REQ-004 SHALL issue at most one RAM operation per cycle: a display read (mem_we=0), a CPU write (mem_we=1), or none (mem_we=0, mem_addr holds).
REQ-005 SHALL compute reserved = FIFO entries + in-flight reads (0..FIFO_DEPTH); a display read is eligible only when reserved<FIFO_DEPTH and disp_ptr<FB_WORDS.
REQ-006 SHALL treat the CPU as eligible when cpu_req=1 and cpu_ack=0.
REQ-007 SHALL grant in priority order: display if eligible and reserved<2 (urgent); else CPU if eligible; else display if eligible.
REQ-008 SHALL, on a CPU grant, drive mem_addr=cpu_addr, mem_wdata=cpu_wdata, mem_we=1, and assert cpu_ack in the following cycle for exactly one cycle.
REQ-009 SHALL, on a display grant, drive mem_addr=disp_ptr, increment disp_ptr, and push mem_rdata into the FIFO one cycle later.
REQ-010 SHALL stop issuing display reads when disp_ptr=FB_WORDS (no wrap) until the next flush.
REQ-011 SHALL flush on the rising edge of vblank: FIFO emptied, disp_ptr=0, and any read in flight that cycle discarded on return. Prefetch resumes the following cycle.
REQ-012 SHALL pop when hblank=0, vblank=0 and CounterX[2:0]=3'b001, registering the popped word to pix_word.
REQ-013 SHALL, on a pop with the FIFO empty, set pix_word=8'h00 and increment underflow_cnt, saturating at 255.
REQ-014 SHALL give flush precedence when flush and pop coincide: no pop, no underflow count.
REQ-015 SHALL, when a push and a pop coincide, leave occupancy unchanged and update pix_word with the head entry.

Reset
REQ-016 SHALL, on Reset=1, asynchronously clear:
- all outputs to 0;
- disp_ptr, FIFO pointers/count and the in-flight flag to 0;
- underflow_cnt to 0.
REQ-017 SHALL drop an unacknowledged CPU write on reset mid-operation; the requester re-presents it.

Configuration
REQ-018 SHALL include the underflow counter when macro FB_SCAN_ARBITER_UNDERFLOW_CNT_EN is defined.
REQ-019 SHALL, without FB_SCAN_ARBITER_UNDERFLOW_CNT_EN, tie underflow_cnt to 8'h00 and synthesize no counter logic; all other behaviour is identical.

Structure
REQ-020 SHALL take the following from shared package fb_pkg: H_ACTIVE=640, V_ACTIVE=480, PIX_PER_WORD=8, FB_ADDR_W=16, FB_DATA_W=8, and the grant enum {GNT_NONE, GNT_DISP, GNT_CPU}.
REQ-021 SHALL place the prefetch FIFO, with synchronous flush and occupancy output, in sub-module fb_prefetch_fifo.

Verification
REQ-022 SHALL cover these scenarios:
- Reset released during vblank, no cpu_req -> reads at addresses 0,1,2,3 in consecutive cycles, then idle with the FIFO full.
- cpu_req=1, cpu_addr=16'h0100, cpu_wdata=8'hA5 while the FIFO is full -> mem_we=1 with that address/data next cycle; cpu_ack pulses once, the cycle after.
- cpu_req held continuously during active video -> display reads still granted whenever reserved<2; zero underflows over a full frame.
- mem_rdata stream 8'h01,8'h02,... -> pix_word updates at each CounterX[2:0]=1 in active area; values in order.
- FIFO forced empty (display reads suppressed by the bench) at a pop -> pix_word=8'h00; underflow_cnt increments. 300 underflows -> underflow_cnt=255.
- vblank rises with one read in flight -> returned word discarded, disp_ptr=0, next read addresses 0.

Source files
------------

// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared framebuffer constants and the RAM-port grant encoding used by the
// scan-out arbiter and its helpers.
// ---------------------------------------------------------------------------
package fb_pkg;

   localparam int H_ACTIVE     = 640;
   localparam int V_ACTIVE     = 480;
   localparam int PIX_PER_WORD = 8;
   localparam int FB_ADDR_W    = 16;
   localparam int FB_DATA_W    = 8;

   // Owner of the single RAM port for the cycle after the grant decision.
   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_DISP = 2'd1,
      GNT_CPU  = 2'd2
   } gnt_e;

endpackage

// File: rtl/fb_prefetch_fifo.sv
// ---------------------------------------------------------------------------
// fb_prefetch_fifo
// Small display prefetch FIFO with synchronous flush and occupancy output.
//
// Ports:
//   Clk, Reset      clock (rising edge), asynchronous active-high reset
//   flush           synchronous clear of pointers and count (wins over push/pop)
//   push, push_data write one word
//   pop             consume the head word
//   head_data       word at the head (valid while !empty)
//   empty           no stored words
//   count           occupancy, 0..DEPTH
//
// A push and pop in the same cycle on an empty FIFO is a pass-through: the
// caller takes push_data directly and nothing is stored.
// ---------------------------------------------------------------------------
module fb_prefetch_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                       Clk,
   input  logic                       Reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic [DATA_W-1:0]          push_data,
   input  logic                       pop,
   output logic [DATA_W-1:0]          head_data,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              wr_en;
   logic              rd_en;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign empty     = (count == '0);
   assign wr_en     = push && !(pop && empty);
   assign rd_en     = pop && !empty;
   assign head_data = mem[rd_ptr];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
         if (rd_en) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge Clk) begin
      if (wr_en && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/fb_scan_arbiter.sv
// ---------------------------------------------------------------------------
// fb_scan_arbiter
// Shares one framebuffer RAM port between display prefetch reads and CPU
// writes, and delivers one 8-pixel word per 8 active columns to the display.
//
// Parameters:
//   FB_WORDS    framebuffer size in words (reads stop at this address)
//   FIFO_DEPTH  prefetch FIFO depth
//
// Ports:
//   Clk, Reset           clock, asynchronous active-high reset
//   CounterX, CounterY   raster position
//   hblank, vblank       blanking flags (vblank rising edge flushes prefetch)
//   mem_addr/we/wdata    registered RAM command (address holds when idle)
//   mem_rdata            RAM data, valid one cycle after the address
//   cpu_req/addr/wdata   CPU write request, held until cpu_ack
//   cpu_ack              one-cycle pulse the cycle after the write
//   pix_word             current display word, MSB = leftmost pixel
//   underflow_cnt        saturating count of pops from an empty FIFO
//
// Build option: define FB_SCAN_ARBITER_UNDERFLOW_CNT_EN to include the
// underflow counter; otherwise underflow_cnt is tied to zero.
// ---------------------------------------------------------------------------
module fb_scan_arbiter
   import fb_pkg::*;
#(
   parameter int FB_WORDS   = 38400,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic [15:0]          CounterX,
   input  logic [15:0]          CounterY,
   input  logic                 hblank,
   input  logic                 vblank,
   output logic [FB_ADDR_W-1:0] mem_addr,
   output logic                 mem_we,
   output logic [FB_DATA_W-1:0] mem_wdata,
   input  logic [FB_DATA_W-1:0] mem_rdata,
   input  logic                 cpu_req,
   input  logic [FB_ADDR_W-1:0] cpu_addr,
   input  logic [FB_DATA_W-1:0] cpu_wdata,
   output logic                 cpu_ack,
   output logic [FB_DATA_W-1:0] pix_word,
   output logic [7:0]           underflow_cnt
);

   localparam int CNT_W = $clog2(FIFO_DEPTH+1);
   localparam int RES_W = CNT_W + 1;
   localparam int PH_W  = $clog2(PIX_PER_WORD);
   localparam logic [FB_ADDR_W-1:0] FB_END = FB_ADDR_W'(FB_WORDS);

   logic [FB_ADDR_W-1:0] disp_ptr;
   logic                 vblank_q;
   logic                 flush;
   logic                 rd_vld_p1;
   logic                 rd_vld_p2;
   logic [CNT_W-1:0]     fifo_count;
   logic                 fifo_empty;
   logic [FB_DATA_W-1:0] fifo_head;
   logic [RES_W-1:0]     reserved;
   logic                 disp_elig;
   logic                 cpu_elig;
   logic                 push;
   logic                 pop;
   gnt_e                 gnt;

   logic unused_ok;
   assign unused_ok = ^{CounterY, CounterX[15:PH_W]};

   assign flush = vblank && !vblank_q;
   assign push  = rd_vld_p2 && !flush;
   assign pop   = !hblank && !vblank && (CounterX[PH_W-1:0] == PH_W'(1)) && !flush;

   // FIFO slots already promised: stored words plus both read stages.
   assign reserved  = RES_W'(fifo_count) + RES_W'(rd_vld_p1) + RES_W'(rd_vld_p2);
   assign disp_elig = !flush && (reserved < RES_W'(FIFO_DEPTH)) && (disp_ptr < FB_END);
   // A write already on the bus (mem_we) is still awaiting its ack.
   assign cpu_elig  = cpu_req && !cpu_ack && !mem_we;

   always_comb begin
      gnt = GNT_NONE;
      if (disp_elig && (reserved < RES_W'(2))) gnt = GNT_DISP;
      else if (cpu_elig)                       gnt = GNT_CPU;
      else if (disp_elig)                      gnt = GNT_DISP;
   end

   // ---- stage p1: registered RAM command; p2: read data returning ----
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         mem_addr  <= '0;
         mem_we    <= 1'b0;
         mem_wdata <= '0;
         cpu_ack   <= 1'b0;
         disp_ptr  <= '0;
         rd_vld_p1 <= 1'b0;
         rd_vld_p2 <= 1'b0;
         // Treat reset as inside vblank so leaving reset is not a flush edge.
         vblank_q  <= 1'b1;
      end else begin
         vblank_q  <= vblank;
         mem_we    <= (gnt == GNT_CPU);
         cpu_ack   <= mem_we;
         rd_vld_p1 <= (gnt == GNT_DISP);
         rd_vld_p2 <= rd_vld_p1 && !flush;
         case (gnt)
            GNT_CPU: begin
               mem_addr  <= cpu_addr;
               mem_wdata <= cpu_wdata;
            end
            GNT_DISP: mem_addr <= disp_ptr;
            default:  ;
         endcase
         if (flush)                disp_ptr <= '0;
         else if (gnt == GNT_DISP) disp_ptr <= disp_ptr + FB_ADDR_W'(1);
      end
   end

   fb_prefetch_fifo #(
      .DATA_W (FB_DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .Clk       (Clk),
      .Reset     (Reset),
      .flush     (flush),
      .push      (push),
      .push_data (mem_rdata),
      .pop       (pop),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // ---- display output: pop into pix_word ----
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         pix_word <= '0;
      end else if (pop) begin
         if (!fifo_empty) pix_word <= fifo_head;
         else if (push)   pix_word <= mem_rdata;
         else             pix_word <= '0;
      end
   end

`ifdef FB_SCAN_ARBITER_UNDERFLOW_CNT_EN
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) underflow_cnt <= '0;
      else if (pop && fifo_empty && !push) underflow_cnt <= sat_inc8(underflow_cnt);
   end
`else
   assign underflow_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fb_scan_arbiter
// Directed and randomized bench for fb_scan_arbiter using a reduced
// framebuffer (64 words) and a compressed raster (96x10 total, 64x8 active).
// Framebuffer word i holds i+1; CPU writes target addresses above the
// framebuffer so display contents stay predictable.
// ---------------------------------------------------------------------------
module tb_fb_scan_arbiter;

   localparam int FBW = 64;
   localparam int HT  = 96;
   localparam int HA  = 64;
   localparam int VT  = 10;
   localparam int VA  = 8;
`ifdef FB_SCAN_ARBITER_UNDERFLOW_CNT_EN
   localparam bit UF_EN = 1'b1;
`else
   localparam bit UF_EN = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] CounterX;
   logic [15:0] CounterY;
   logic        hblank;
   logic        vblank;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;
   logic        cpu_req;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  pix_word;
   logic [7:0]  underflow_cnt;

   int checks = 0;
   int errors = 0;

   int   frame_idx = 0;
   int   uf_model  = 0;
   logic [7:0] exp_pix;
   logic vblank_prev = 1'b1;
   bit   raster_en = 1'b0;
   bit   y_freeze  = 1'b0;
   int   rx = 0;
   int   ry = VA;
   bit   cpu_auto = 1'b0;
   bit   cpu_hold = 1'b0;
   int   wr_cnt   = 0;
   int   wait_cnt = 0;
   int   acks     = 0;

   fb_scan_arbiter #(
      .FB_WORDS   (FBW),
      .FIFO_DEPTH (4)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .CounterX      (CounterX),
      .CounterY      (CounterY),
      .hblank        (hblank),
      .vblank        (vblank),
      .mem_addr      (mem_addr),
      .mem_we        (mem_we),
      .mem_wdata     (mem_wdata),
      .mem_rdata     (mem_rdata),
      .cpu_req       (cpu_req),
      .cpu_addr      (cpu_addr),
      .cpu_wdata     (cpu_wdata),
      .cpu_ack       (cpu_ack),
      .pix_word      (pix_word),
      .underflow_cnt (underflow_cnt)
   );

   always #5 Clk = ~Clk;

   function automatic logic [7:0] fb_word(input int i);
      return 8'(i + 1);
   endfunction

   // Synchronous RAM: data for the address on the bus appears next cycle.
   always @(posedge Clk) mem_rdata <= fb_word(int'(mem_addr));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic present_new();
      cpu_req   = 1'b1;
      cpu_addr  = 16'h0100 + 16'($urandom_range(255, 0));
      cpu_wdata = 8'($urandom);
      wr_cnt    = 0;
      wait_cnt  = 0;
   endtask

   task automatic cpu_agent();
      if (mem_we) begin
         check("cpu_wr_addr", 32'(mem_addr), 32'(cpu_addr));
         check("cpu_wr_data", 32'(mem_wdata), 32'(cpu_wdata));
         wr_cnt++;
      end
      if (cpu_ack) begin
         check("cpu_ack_once", wr_cnt, 1);
         acks++;
         if (cpu_hold || ($urandom_range(1, 0) == 1)) present_new();
         else cpu_req = 1'b0;
      end else if (cpu_req) begin
         wait_cnt++;
         if (wait_cnt > 16) begin
            check("cpu_timeout", wait_cnt, 16);
            cpu_req = 1'b0;
         end
      end else if ($urandom_range(3, 0) == 0) begin
         present_new();
      end
   endtask

   task automatic advance_raster();
      if (rx == HT - 1) begin
         rx = 0;
         if (!y_freeze) ry = (ry == VT - 1) ? 0 : ry + 1;
      end else begin
         rx++;
      end
      CounterX = 16'(rx);
      CounterY = 16'(ry);
      hblank   = (rx >= HA);
      vblank   = (ry >= VA);
   endtask

   // One clock: predict pops/flushes from the inputs presented this cycle,
   // then sample outputs just after the edge.
   task automatic tick();
      logic pop_now;
      logic flush_now;
      pop_now   = !hblank && !vblank && (CounterX[2:0] == 3'b001);
      flush_now = vblank && !vblank_prev;
      @(posedge Clk);
      #1;
      vblank_prev = vblank;
      if (flush_now) begin
         frame_idx = 0;
      end else if (pop_now) begin
         if (frame_idx < FBW) begin
            exp_pix = fb_word(frame_idx);
         end else begin
            exp_pix = 8'h00;
            if (uf_model < 255) uf_model++;
         end
         frame_idx++;
         check("pix_word", 32'(pix_word), 32'(exp_pix));
         check("underflow_cnt", 32'(underflow_cnt), UF_EN ? 32'(uf_model) : 32'd0);
      end
      if (cpu_auto) cpu_agent();
      if (raster_en) advance_raster();
   endtask

   initial begin
      Reset     = 1'b1;
      CounterX  = 16'd0;
      CounterY  = 16'(VA);
      hblank    = 1'b1;
      vblank    = 1'b1;
      cpu_req   = 1'b0;
      cpu_addr  = 16'h0000;
      cpu_wdata = 8'h00;

      // Reset state.
      repeat (3) @(posedge Clk);
      #1;
      check("rst_mem_addr", 32'(mem_addr), 0);
      check("rst_mem_we", 32'(mem_we), 0);
      check("rst_mem_wdata", 32'(mem_wdata), 0);
      check("rst_cpu_ack", 32'(cpu_ack), 0);
      check("rst_pix_word", 32'(pix_word), 0);
      check("rst_underflow", 32'(underflow_cnt), 0);
      Reset = 1'b0;

      // Release during vblank: four back-to-back reads, then idle.
      for (int i = 0; i < 4; i++) begin
         tick();
         check("init_rd_addr", 32'(mem_addr), i);
         check("init_rd_we", 32'(mem_we), 0);
      end
      repeat (4) tick();
      check("idle_full_addr", 32'(mem_addr), 3);
      check("idle_full_we", 32'(mem_we), 0);

      // CPU write while FIFO full.
      cpu_req   = 1'b1;
      cpu_addr  = 16'h0100;
      cpu_wdata = 8'hA5;
      tick();
      check("cpu_we", 32'(mem_we), 1);
      check("cpu_addr", 32'(mem_addr), 32'h0100);
      check("cpu_wdata", 32'(mem_wdata), 32'hA5);
      check("cpu_ack_early", 32'(cpu_ack), 0);
      tick();
      check("cpu_ack", 32'(cpu_ack), 1);
      check("cpu_we_after", 32'(mem_we), 0);
      cpu_req = 1'b0;
      tick();
      check("cpu_ack_single", 32'(cpu_ack), 0);
      check("cpu_addr_hold", 32'(mem_addr), 32'h0100);

      // Frames: first with random CPU traffic, second with CPU held busy.
      raster_en = 1'b1;
      rx = 0;
      ry = VA;
      cpu_auto = 1'b1;
      repeat (2 * HT) tick();
      repeat (VT * HT) tick();
      cpu_hold = 1'b1;
      acks = 0;
      repeat (VT * HT) tick();
      check("hold_no_underflow", 32'(underflow_cnt), 0);
      check("hold_cpu_progress", 32'(acks > 100), 1);

      // Extended active area: framebuffer exhausts, pops underflow.
      cpu_hold = 1'b0;
      y_freeze = 1'b1;
      repeat (47 * HT) tick();
      check("uf_saturated", 32'(underflow_cnt), UF_EN ? 32'd255 : 32'd0);
      check("uf_pix_zero", 32'(pix_word), 0);

      // Flush with a read in flight.
      y_freeze  = 1'b0;
      raster_en = 1'b0;
      cpu_auto  = 1'b0;
      cpu_req   = 1'b0;
      CounterX  = 16'd0;
      hblank    = 1'b1;
      vblank    = 1'b1;
      repeat (12) tick();
      check("refill_addr", 32'(mem_addr), 3);
      CounterX = 16'd1;
      hblank   = 1'b0;
      vblank   = 1'b0;
      tick();
      CounterX = 16'd2;
      tick();
      check("inflight_addr", 32'(mem_addr), 4);
      hblank = 1'b1;
      vblank = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         tick();
         check("post_flush_addr", 32'(mem_addr), i);
      end
      repeat (4) tick();
      hblank = 1'b0;
      vblank = 1'b0;
      for (int k = 0; k < 32; k++) begin
         CounterX = 16'(k);
         tick();
      end
      check("post_flush_pops", frame_idx, 4);

      // Reset in the middle of a CPU write drops it.
      hblank    = 1'b1;
      vblank    = 1'b1;
      cpu_req   = 1'b1;
      cpu_addr  = 16'h0155;
      cpu_wdata = 8'h3C;
      begin
         int n;
         n = 0;
         tick();
         while (!mem_we && n < 8) begin
            tick();
            n++;
         end
      end
      check("rst_pre_we", 32'(mem_we), 1);
      #2;
      Reset = 1'b1;
      #1;
      check("async_rst_we", 32'(mem_we), 0);
      check("async_rst_ack", 32'(cpu_ack), 0);
      check("async_rst_addr", 32'(mem_addr), 0);
      check("async_rst_pix", 32'(pix_word), 0);
      check("async_rst_uf", 32'(underflow_cnt), 0);
      @(posedge Clk);
      #1;
      Reset   = 1'b0;
      cpu_req = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
